// File: rtl/sext_arbiter.sv
// sext_arbiter: two requesters share one immediate-extension datapath.
// A round-robin arbiter grants one request per cycle into a single-entry
// registered output slot (EMPTY/FULL FSM) with valid/ready handshakes.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/imm/mode/ready  requester handshakes (0 = decode, 1 = branch-target)
//   out_valid/ready/data/id    result handshake, extended value, winning requester
module sext_arbiter #(
  parameter int unsigned INPUT_BITS  = 16,
  parameter int unsigned OUTPUT_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  input  logic [INPUT_BITS-1:0]  req0_imm,
  input  logic [1:0]             req0_mode,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [INPUT_BITS-1:0]  req1_imm,
  input  logic [1:0]             req1_mode,
  output logic                   req1_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUTPUT_BITS-1:0] out_data,
  output logic                   out_id
);

  localparam int unsigned EXT_BITS = OUTPUT_BITS - INPUT_BITS;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_last;
  logic [OUTPUT_BITS-1:0] r_data;
  logic                   r_id;

  logic                   w_gnt_vld;
  logic                   w_gnt_id;
  logic                   w_free;
  logic                   w_accept;
  logic                   w_rdy0;
  logic                   w_rdy1;
  logic [INPUT_BITS-1:0]  w_imm;
  logic [1:0]             w_mode;
  logic [OUTPUT_BITS-1:0] w_sext;
  logic [OUTPUT_BITS-1:0] w_ext;

  // Round-robin pick: on contention favour the requester not granted last.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = ~r_last;
    end else if (req0_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b0;
    end else if (req1_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b1;
    end
  end

  // Output-slot FSM: next state and grant handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_free      = 1'b0;
    w_accept    = 1'b0;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    // Slot may be refilled in the same cycle it drains.
    w_free   = (r_state == EMPTY) || out_ready;
    w_accept = w_free && w_gnt_vld && rst_n;
    w_rdy0   = w_accept && !w_gnt_id;
    w_rdy1   = w_accept &&  w_gnt_id;
    case (r_state)
      EMPTY: if (w_accept) w_state_nxt = FULL;
      FULL:  if (out_ready && !w_accept) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Shared extension datapath, fed by the granted requester only.
  always_comb begin
    w_imm  = w_gnt_id ? req1_imm  : req0_imm;
    w_mode = w_gnt_id ? req1_mode : req0_mode;
    w_sext = {{EXT_BITS{w_imm[INPUT_BITS-1]}}, w_imm};
    case (w_mode)
      2'b00:   w_ext = w_sext;
      2'b01:   w_ext = {{EXT_BITS{1'b0}}, w_imm};
      2'b10:   w_ext = {w_imm, {EXT_BITS{1'b0}}};
      default: w_ext = w_sext << 2;
    endcase
  end

  // Result slot and last-grant pointer; pointer resets to 1 so req0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_data <= w_ext;
      r_id   <= w_gnt_id;
      r_last <= w_gnt_id;
    end
  end

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign out_valid  = (r_state == FULL);
  assign out_data   = r_data;
  assign out_id     = r_id;

endmodule

// File: tb/tb_sext_arbiter.sv
// Directed bench for sext_arbiter: mode coverage, contention, backpressure,
// lone requester and asynchronous reset mid-operation.
module tb_sext_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [15:0] req0_imm;
  logic [1:0]  req0_mode;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_imm;
  logic [1:0]  req1_mode;
  logic        req1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_id;

  int n_checks;
  int n_pass;

  sext_arbiter #(.INPUT_BITS(16), .OUTPUT_BITS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_imm   (req0_imm),
    .req0_mode  (req0_mode),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_imm   (req1_imm),
    .req1_mode  (req1_mode),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input string tag, input logic e0, input logic e1);
    check({tag, "_rdy0"}, 32'(req0_ready), 32'(e0));
    check({tag, "_rdy1"}, 32'(req1_ready), 32'(e1));
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] ed, input logic eid);
    check({tag, "_vld"},  32'(out_valid), 32'(ev));
    check({tag, "_data"}, out_data, ed);
    check({tag, "_id"},   32'(out_id), 32'(eid));
  endtask

  logic [31:0] mode_exp [4];
  logic [31:0] cont_exp [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mode_exp[0] = 32'hFFFF8001;
    mode_exp[1] = 32'h00008001;
    mode_exp[2] = 32'h80010000;
    mode_exp[3] = 32'hFFFE0004;
    cont_exp[0] = 32'h00000011;
    cont_exp[1] = 32'h00000022;
    cont_exp[2] = 32'h00000011;
    cont_exp[3] = 32'h00000022;

    // Reset held with requests pending: nothing granted, slot cleared.
    rst_n      = 1'b0;
    req0_valid = 1'b1; req0_imm = 16'h1234; req0_mode = 2'b00;
    req1_valid = 1'b1; req1_imm = 16'h5678; req1_mode = 2'b00;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_ready("rst", 1'b0, 1'b0);
    chk_out("rst", 1'b0, 32'h0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    // Mode coverage: req0 alone, imm 8001, each mode.
    req0_valid = 1'b1; req0_imm = 16'h8001;
    for (int m = 0; m < 4; m++) begin
      req0_mode = 2'(m);
      @(negedge clk);
      chk_ready($sformatf("mode%0d", m), 1'b1, 1'b0);
      after_edge();
      chk_out($sformatf("mode%0d", m), 1'b1, mode_exp[m], 1'b0);
    end
    req0_valid = 1'b0;
    after_edge();
    check("drain_vld", 32'(out_valid), 32'h0);

    // Fresh reset, then contention every cycle: grants alternate 0,1,0,1.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_imm = 16'h0011; req0_mode = 2'b01;
    req1_valid = 1'b1; req1_imm = 16'h0022; req1_mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_ready($sformatf("cont%0d", i), (i % 2) == 0, (i % 2) == 1);
      after_edge();
      chk_out($sformatf("cont%0d", i), 1'b1, cont_exp[i], 1'(i % 2));
    end

    // Backpressure: slot holds req1's result, nobody granted.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_ready($sformatf("bp%0d", i), 1'b0, 1'b0);
      after_edge();
      chk_out($sformatf("bp%0d", i), 1'b1, 32'h00000022, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_ready("bp_rel", 1'b1, 1'b0);
    after_edge();
    chk_out("bp_rel", 1'b1, 32'h00000011, 1'b0);

    // Lone requester 1 for three cycles.
    req0_valid = 1'b0;
    req1_imm = 16'h7FFF; req1_mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_ready($sformatf("lone%0d", i), 1'b0, 1'b1);
      after_edge();
      chk_out($sformatf("lone%0d", i), 1'b1, 32'h00007FFF, 1'b1);
    end
    req1_valid = 1'b0;
    after_edge();
    check("lone_drain", 32'(out_valid), 32'h0);
    // Pointer now 1: contention picks req0.
    req0_valid = 1'b1; req0_imm = 16'h0003; req0_mode = 2'b11;
    req1_valid = 1'b1;
    @(negedge clk);
    chk_ready("ptr", 1'b1, 1'b0);
    after_edge();
    chk_out("ptr", 1'b1, 32'h0000000C, 1'b0);

    // Reset mid-operation while FULL and stalled.
    out_ready = 1'b0;
    after_edge();
    check("pre_rst_vld", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 32'h0, 1'b0);
    chk_ready("mid_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk_ready("post_rst", 1'b1, 1'b0);
    after_edge();
    chk_out("post_rst", 1'b1, 32'h0000000C, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sext_arbiter.md
SEXT_ARBITER -- requirements
Module: sext_arbiter

Interface
REQ-001 SHALL have parameter INPUT_BITS, default 16, width of the immediate field.
REQ-002 SHALL have parameter OUTPUT_BITS, default 32, width of the extended result; OUTPUT_BITS > INPUT_BITS+2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1 each  requester has an immediate to extend (0 = decode stage, 1 = branch-target unit).
REQ-006 SHALL have ports req0_imm / req1_imm  input  INPUT_BITS each  raw immediate.
REQ-007 SHALL have ports req0_mode / req1_mode  input  2 each  00 sign-extend, 01 zero-extend, 10 upper (imm placed at MSBs, low bits 0), 11 sign-extend then shift left 2.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1 each  request accepted this cycle when valid and ready are both 1.
REQ-009 SHALL have port out_valid  output  1  out_data holds a result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result when out_valid and out_ready are both 1.
REQ-011 SHALL have port out_data  output  OUTPUT_BITS  extended result.
REQ-012 SHALL have port out_id  output  1  index of the requester that produced out_data.

Function
REQ-013 SHALL share one extension datapath between the two requesters; at most one request is accepted per cycle.
REQ-014 SHALL use a two-state output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL treat the slot as free when the FSM is in EMPTY, or in FULL with out_ready=1 (drain and refill in the same cycle).
REQ-016 SHALL grant only when the slot is free; reqN_ready is 1 only for the granted requester, and is a combinational function of state, valids and out_ready.
REQ-017 SHALL arbitrate round-robin with a 1-bit last-grant pointer; on contention, grant the requester that was not granted last.
REQ-018 SHALL grant a lone valid requester regardless of the pointer; the pointer updates only on an accepted grant.
REQ-019 SHALL register the result: on acceptance at edge N, out_data, out_id and out_valid=1 appear after edge N, giving 1-cycle latency.
REQ-020 SHALL compute mode 00 as the MSB replicated into the upper OUTPUT_BITS-INPUT_BITS bits.
REQ-021 SHALL compute mode 01 as the upper bits forced to 0.
REQ-022 SHALL compute mode 10 as {imm, zeros}, i.e. imm in bits [OUTPUT_BITS-1:OUTPUT_BITS-INPUT_BITS] and the rest 0.
REQ-023 SHALL compute mode 11 as (sign-extended imm) << 2, truncated to OUTPUT_BITS.
REQ-024 SHALL hold out_data and out_id stable while FULL and out_ready=0.
REQ-025 SHALL go FULL->EMPTY on out_ready=1 with no new grant, and stay FULL on out_ready=1 with a new grant, loading the new data.
REQ-026 SHALL ignore reqN_imm and reqN_mode when reqN_valid=0.
REQ-027 SHALL contain no combinational path from req*_valid to out_valid.

Reset
REQ-028 SHALL, while rst_n=0, force FSM=EMPTY, out_valid=0, out_data=0, out_id=0 and last-grant pointer=1, so requester 0 wins first contention.
REQ-029 SHALL drive req0_ready=req1_ready=0 while rst_n=0.
REQ-030 SHALL discard any held result when reset asserts mid-operation; after deassertion, the first accepted request behaves exactly as after power-up.

Verification
REQ-031 SHALL be checked for mode coverage: req0 alone, imm=16'h8001, each mode in turn, out_ready=1 -> out_data 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, one cycle after each acceptance, out_id=0.
REQ-032 SHALL be checked for contention: both valid every cycle after reset, out_ready=1 -> grants alternate 0,1,0,1; out_id follows the same sequence; no idle cycles.
REQ-033 SHALL be checked for backpressure: out_ready=0 for 5 cycles while FULL, both valid -> both ready=0, out_data stable; on out_ready=1, next grant and refill occur the same cycle.
REQ-034 SHALL be checked for a lone requester: req1 only, valid for 3 cycles, imm=16'h7FFF, mode 00 -> three results 32'h00007FFF, all out_id=1, pointer=1 afterwards.
REQ-035 SHALL be checked for reset mid-operation: FULL with out_ready=0, assert rst_n=0 asynchronously between edges -> out_valid drops immediately; after release, req0/req1 contention grants req0 first.
